tri_stream_drv: RTL and testbench
=================================

// Module: tri_stream_drv
// PURPOSE
//  Source end of the rasterizer triangle interface: buffers bench-written triangles and issues them
//  with a valid/halt handshake, stamping each with a tri_id and end-of-stream marker. Inserts GAP idle
//  cycles between triangles so identical consecutive triangles stay distinct at hit-count checkers.
// PARAMETERS
//  SIGFIG  24  bits per coordinate/color component
//  RADIX   10  fraction bits (informational; data passed unmodified)
//  VERTS   3   vertices per triangle
//  AXIS    3   axes per vertex (x,y,z)
//  COLORS  3   color channels
//  DEPTH   16  triangle buffer entries; power of 2, >=2
//  GAP     1   idle cycles forced between issued triangles; 0..15
// PORTS
//  clk           in   1                  clock
//  rst           in   1                  reset, synchronous, active-low
//  wr_en_H       in   1                  write one triangle into buffer
//  wr_tri_S      in   SIGFIG[VERTS][AXIS] triangle vertices
//  wr_color_U    in   SIGFIG[COLORS]     triangle color
//  wr_last_H     in   1                  qualifies wr_en_H: this triangle ends the stream
//  full_H        out  1                  buffer holds DEPTH entries
//  ovf_H         out  1                  sticky: write attempted while full
//  start_H       in   1                  one-cycle pulse: begin issuing
//  halt_RnnnnL   in   1                  downstream ready; 0 = stall
//  tri_R10S      out  SIGFIG[VERTS][AXIS] issued triangle
//  color_R10U    out  SIGFIG[COLORS]     issued color
//  validTri_R10H out  1                  tri/color/id/last valid
//  tri_id_R10U   out  16                 issue sequence number, wraps 0xFFFF->0
//  last_R10H     out  1                  issued triangle is end of stream
//  done_H        out  1                  one-cycle pulse after last triangle accepted
//  busy_H        out  1                  FSM not in IDLE
// BEHAVIOUR
//  Reset (rst==0 at posedge): every output 0, buffer empty, ovf cleared, tri_id counter 0, FSM IDLE.
//  Reset mid-stream discards buffered and in-flight triangles; no done_H pulse.
//  Buffer: write accepted when wr_en_H && (!full_H || pop same cycle); else dropped, ovf_H set.
//   Pop and write same cycle while full: both happen, count unchanged. Pointers wrap mod DEPTH.
//  Transfer: completes on posedge with validTri_R10H && halt_RnnnnL. While halt_RnnnnL==0 all
//   R10 outputs held stable. validTri_R10H never drops without a transfer.
//  FSM: IDLE -start_H-> LOAD.  LOAD: if buffer non-empty pop head into R10 regs, valid=1 next cycle
//   -> SEND; if empty stay LOAD, valid=0 (underrun waits, no error).  SEND: on transfer, if last_R10H
//   -> DONE else if GAP==0 and non-empty pop next head directly (back-to-back, 1 tri/cycle)
//   else -> GAPW.  GAPW: valid=0 for GAP cycles -> LOAD.  DONE: done_H=1 one cycle -> IDLE.
//  start_H outside IDLE ignored. Latency: start_H with non-empty buffer -> validTri 2 cycles later.
//  tri_id increments by 1 per transfer; first triangle after reset has id 0; no reset on DONE.
//  Entries written after a wr_last_H entry remain buffered for the next start_H.
//  busy_H = (state != IDLE), registered.
// STRUCTURE
//  Package tri_stream_pkg: typedef tri_t (logic signed [SIGFIG-1:0] [VERTS][AXIS]), color_t,
//   tri_entry_t {tri_t, color_t, last}; enum drv_state_e {IDLE,LOAD,SEND,GAPW,DONE}.
//  Sub-module tri_entry_fifo: sync FIFO of tri_entry_t, DEPTH, push/pop/full/empty, same-cycle
//   push+pop when full. Top: FSM, gap counter, id counter, R10 output registers.
// TESTING
//  1 Write 3 tris (last on 3rd), start, halt=1, GAP=1 -> valid at t+2, t+4, t+6; ids 0,1,2; last on
//    id 2; done_H 1 cycle after third transfer.
//  2 GAP=0, 4 identical tris -> 4 consecutive valid cycles, outputs identical, ids 0..3 distinguish.
//  3 halt=0 for 5 cycles while valid -> outputs frozen; transfer on first halt=1 edge; no loss/dup.
//  4 Write DEPTH+1 tris, no pop -> full_H after DEPTH, 17th dropped, ovf_H=1 until reset.
//  5 Start with empty buffer, write 1 last tri 10 cycles later -> valid 2 cycles after write.
//  6 rst=0 while valid and 4 buffered -> next cycle all outputs 0, empty; new stream restarts id 0.

Source files
------------

// File: rtl/tri_stream_drv_pkg.sv
// Shared types for the rasterizer triangle source: coordinate/color packing,
// buffered entry layout and the issue FSM state encoding.
package tri_stream_pkg;

  localparam int SIGFIG = 24;  // bits per coordinate / color component
  localparam int RADIX  = 10;  // fraction bits; data is passed through unmodified
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;

  typedef struct packed {
    tri_t   vtx;
    color_t color;
    logic   last;
  } tri_entry_t;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAPW, DONE} drv_state_e;

endpackage

// File: rtl/tri_stream_drv_if.sv
// Issued-triangle stream with valid/halt handshake. The driver is the master;
// the rasterizer (or checker) is the slave and returns halt_RnnnnL as ready.
interface tri_stream_drv_if;
  import tri_stream_pkg::*;

  tri_t        tri_R10S;
  color_t      color_R10U;
  logic        validTri_R10H;
  logic [15:0] tri_id_R10U;
  logic        last_R10H;
  logic        halt_RnnnnL;

  modport master (
    output tri_R10S, color_R10U, validTri_R10H, tri_id_R10U, last_R10H,
    input  halt_RnnnnL
  );

  modport slave (
    input  tri_R10S, color_R10U, validTri_R10H, tri_id_R10U, last_R10H,
    output halt_RnnnnL
  );
endinterface

// File: rtl/tri_entry_fifo.sv
// Synchronous FIFO of triangle entries. A push while full is still accepted
// when a pop happens in the same cycle, so a full buffer can stream at rate.
module tri_entry_fifo
  import tri_stream_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  tri_entry_t din,
  output tri_entry_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  tri_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only the pointers and count define
  // what is valid, which keeps the array as plain RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/tri_stream_drv.sv
// Source end of the rasterizer triangle interface: buffers written triangles and
// issues them with tri_id/last stamps, forcing GAP idle cycles between triangles.
module tri_stream_drv
  import tri_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP   = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_en_H,
  input  tri_t   wr_tri_S,
  input  color_t wr_color_U,
  input  logic   wr_last_H,
  output logic   full_H,
  output logic   ovf_H,
  input  logic   start_H,
  tri_stream_drv_if.master tx,
  output logic   done_H,
  output logic   busy_H
);
  // The LOAD cycle counts as one of the idle cycles, so GAPW only covers the rest.
  localparam logic [3:0] GAP_RELOAD = (GAP >= 2) ? 4'(GAP - 2) : 4'd0;

  drv_state_e state;
  logic [3:0] gap_cnt;
  logic       empty;
  logic       pop;
  logic       xfer;
  tri_entry_t head;
  tri_entry_t wr_entry;

  assign xfer     = tx.validTri_R10H && tx.halt_RnnnnL;
  assign wr_entry = '{vtx: wr_tri_S, color: wr_color_U, last: wr_last_H};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pop = 1'b0;
    case (state)
      LOAD:    pop = !empty;
      SEND:    pop = xfer && !tx.last_R10H && (GAP == 0) && !empty;
      default: pop = 1'b0;
    endcase
  end

  tri_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en_H),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .full  (full_H),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      gap_cnt          <= '0;
      ovf_H            <= 1'b0;
      done_H           <= 1'b0;
      busy_H           <= 1'b0;
      tx.tri_R10S      <= '0;
      tx.color_R10U    <= '0;
      tx.validTri_R10H <= 1'b0;
      tx.tri_id_R10U   <= '0;
      tx.last_R10H     <= 1'b0;
    end else begin
      done_H <= 1'b0;
      if (wr_en_H && full_H && !pop) ovf_H <= 1'b1;
      if (xfer) tx.tri_id_R10U <= tx.tri_id_R10U + 16'd1;
      // The head is loaded on every pop; pop only asserts in LOAD or a back-to-back SEND.
      if (pop) begin
        tx.tri_R10S   <= head.vtx;
        tx.color_R10U <= head.color;
        tx.last_R10H  <= head.last;
      end

      case (state)
        IDLE: begin
          if (start_H) begin
            state  <= LOAD;
            busy_H <= 1'b1;
          end
        end
        LOAD: begin
          if (!empty) begin
            tx.validTri_R10H <= 1'b1;
            state            <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (tx.last_R10H) begin
              tx.validTri_R10H <= 1'b0;
              done_H           <= 1'b1;
              state            <= DONE;
            end else if (!pop) begin
              tx.validTri_R10H <= 1'b0;
              gap_cnt          <= GAP_RELOAD;
              state            <= (GAP >= 2) ? GAPW : LOAD;
            end
          end
        end
        GAPW: begin
          if (gap_cnt == '0) state <= LOAD;
          else               gap_cnt <= gap_cnt - 4'd1;
        end
        DONE: begin
          state  <= IDLE;
          busy_H <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_H <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_stream_drv.sv
// Drives a GAP=1 and a GAP=0 driver with the same stimulus and compares both
// every cycle against a queue-based model of the issue rules.
module tb_tri_stream_drv;
  import tri_stream_pkg::*;

  localparam int DEPTH = 16;
  typedef logic [511:0] word_t;

  logic   clk = 1'b0;
  logic   rst;
  logic   wr_en, wr_last, start, halt;
  tri_t   wr_tri;
  color_t wr_color;
  logic [1:0] full, ovf, done, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  tri_stream_drv_if sif0 ();
  tri_stream_drv_if sif1 ();
  assign sif0.halt_RnnnnL = halt;
  assign sif1.halt_RnnnnL = halt;

  tri_stream_drv #(.DEPTH(DEPTH), .GAP(1)) u_dut_g1 (
    .clk(clk), .rst(rst), .wr_en_H(wr_en), .wr_tri_S(wr_tri), .wr_color_U(wr_color),
    .wr_last_H(wr_last), .full_H(full[0]), .ovf_H(ovf[0]), .start_H(start),
    .tx(sif0.master), .done_H(done[0]), .busy_H(busy[0])
  );

  tri_stream_drv #(.DEPTH(DEPTH), .GAP(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .wr_en_H(wr_en), .wr_tri_S(wr_tri), .wr_color_U(wr_color),
    .wr_last_H(wr_last), .full_H(full[1]), .ovf_H(ovf[1]), .start_H(start),
    .tx(sif1.master), .done_H(done[1]), .busy_H(busy[1])
  );

  // Reference model, index 0 = GAP 1, index 1 = GAP 0.
  tri_entry_t  mq [2][$];
  tri_entry_t  m_out [2];
  bit          m_stream [2], m_valid [2], m_busy [2], m_done [2], m_ovf [2];
  logic [15:0] m_id [2];
  int          m_earliest [2];

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 25)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Next valid cycle v needs an entry buffered during v-1 and v >= earliest,
  // where earliest is start+2 or previous transfer + 1 + GAP.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int g;
      bit xfer, free;
      g = (i == 0) ? 1 : 0;
      if (!rst) begin
        mq[i].delete();
        m_out[i] = '0; m_stream[i] = 0; m_valid[i] = 0; m_busy[i] = 0;
        m_done[i] = 0; m_ovf[i] = 0; m_id[i] = '0; m_earliest[i] = 0;
      end else begin
        xfer = m_valid[i] && halt;
        free = 0;
        m_done[i] = 0;
        if (xfer) begin
          m_id[i]    = m_id[i] + 16'd1;
          m_valid[i] = 0;
          if (m_out[i].last) begin
            m_stream[i] = 0;
            m_done[i]   = 1;
          end else begin
            free = 1;
            m_earliest[i] = cyc + 1 + g;
          end
        end else if (m_stream[i] && !m_valid[i]) begin
          free = 1;
        end
        if (free && mq[i].size() > 0 && cyc + 1 >= m_earliest[i]) begin
          m_out[i]   = mq[i].pop_front();
          m_valid[i] = 1;
        end
        if (!m_busy[i] && start) begin
          m_stream[i]   = 1;
          m_earliest[i] = cyc + 2;
        end
        m_busy[i] = m_stream[i] || m_done[i];
        if (wr_en) begin
          if (mq[i].size() < DEPTH)
            mq[i].push_back('{vtx: wr_tri, color: wr_color, last: wr_last});
          else
            m_ovf[i] = 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_one(input int i, input logic v, input logic [15:0] id,
                             input tri_entry_t d, input logic f, input logic o,
                             input logic dn, input logic b);
    string p;
    p = (i == 0) ? "gap1" : "gap0";
    check({p, "_valid"}, word_t'(v),  word_t'(m_valid[i]));
    check({p, "_id"},    word_t'(id), word_t'(m_id[i]));
    check({p, "_data"},  word_t'(d),  word_t'(m_out[i]));
    check({p, "_full"},  word_t'(f),  word_t'(mq[i].size() == DEPTH));
    check({p, "_ovf"},   word_t'(o),  word_t'(m_ovf[i]));
    check({p, "_done"},  word_t'(dn), word_t'(m_done[i]));
    check({p, "_busy"},  word_t'(b),  word_t'(m_busy[i]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_one(0, sif0.validTri_R10H, sif0.tri_id_R10U,
                {sif0.tri_R10S, sif0.color_R10U, sif0.last_R10H},
                full[0], ovf[0], done[0], busy[0]);
    compare_one(1, sif1.validTri_R10H, sif1.tri_id_R10U,
                {sif1.tri_R10S, sif1.color_R10U, sif1.last_R10H},
                full[1], ovf[1], done[1], busy[1]);
    wr_en = 1'b0; wr_last = 1'b0; start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic wr_entry(input tri_entry_t e);
    wr_tri = e.vtx; wr_color = e.color; wr_last = e.last; wr_en = 1'b1;
  endtask

  function automatic tri_entry_t rand_entry(input bit last);
    tri_entry_t e;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        e.vtx[v][a] = SIGFIG'($urandom);
    for (int c = 0; c < COLORS; c++)
      e.color[c] = SIGFIG'($urandom);
    e.last = last;
    return e;
  endfunction

  initial begin
    tri_entry_t same;
    rst = 1'b0; wr_en = 1'b0; wr_last = 1'b0; start = 1'b0; halt = 1'b1;
    wr_tri = '0; wr_color = '0;
    for (int i = 0; i < 2; i++) begin
      m_out[i] = '0; m_stream[i] = 0; m_valid[i] = 0; m_busy[i] = 0;
      m_done[i] = 0; m_ovf[i] = 0; m_id[i] = '0; m_earliest[i] = 0;
    end

    // Three triangles, last on the third, free-running sink.
    do_reset();
    for (int k = 0; k < 3; k++) begin wr_entry(rand_entry(k == 2)); tick(); end
    start = 1'b1; tick();
    repeat (10) tick();

    // Four identical triangles: only tri_id tells them apart.
    do_reset();
    same = rand_entry(1'b0);
    for (int k = 0; k < 4; k++) begin
      same.last = (k == 3);
      wr_entry(same); tick();
    end
    start = 1'b1; tick();
    repeat (10) tick();

    // Sink stalls for several cycles while a triangle is presented.
    wr_entry(rand_entry(1'b0)); tick();
    wr_entry(rand_entry(1'b1)); tick();
    halt = 1'b0; start = 1'b1; tick();
    repeat (7) tick();
    halt = 1'b1;
    repeat (8) tick();

    // Overfill: the seventeenth write is dropped and ovf sticks, then drain
    // with writes landing on a full buffer in pop cycles.
    do_reset();
    for (int k = 0; k < DEPTH + 1; k++) begin wr_entry(rand_entry(k == DEPTH - 1)); tick(); end
    start = 1'b1; tick();
    repeat (45) begin
      if ($urandom_range(0, 1) == 1) wr_entry(rand_entry(1'b0));
      tick();
    end

    // Start on an empty buffer, the triangle arrives later.
    do_reset();
    start = 1'b1; tick();
    repeat (10) tick();
    wr_entry(rand_entry(1'b1)); tick();
    repeat (6) tick();

    // Reset mid-stream with entries still buffered, then a fresh stream.
    do_reset();
    for (int k = 0; k < 6; k++) begin wr_entry(rand_entry(k == 5)); tick(); end
    start = 1'b1; tick();
    repeat (2) tick();
    rst = 1'b0; tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin wr_entry(rand_entry(k == 2)); tick(); end
    start = 1'b1; tick();
    repeat (12) tick();

    // Random traffic with stalls, restarts and occasional resets.
    repeat (3000) begin
      rst   = ($urandom_range(0, 599) != 0);
      halt  = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) < 4) wr_entry(rand_entry($urandom_range(0, 5) == 0));
      tick();
    end
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
